// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: opcodes, control-bundle bit positions and
// the packed control bundle carried from decode into execute.
package rv_pipe_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU_I = 7'b0010011;
    localparam logic [6:0] OPC_ALU_R = 7'b0110011;

    localparam int CTRL_ALU_OP0   = 0;
    localparam int CTRL_ALU_OP1   = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_READ  = 3;
    localparam int CTRL_REG_WRITE = 4;
    localparam int CTRL_MEM2REG   = 5;
    localparam int CTRL_ALU_SRC   = 6;
    localparam int CTRL_STORE_IMM = 7;

    // Field order matches the bit positions above (MSB first).
    typedef struct packed {
        logic store_imm;
        logic alu_src;
        logic mem2reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_op1;
        logic alu_op0;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic opcode_legal(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE) ||
               (opc == OPC_ALU_I) || (opc == OPC_ALU_R);
    endfunction

    function automatic logic opcode_uses_rs2(input logic [6:0] opc);
        return (opc == OPC_ALU_R) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the instruction in
// decode and a load sitting in execute.
module hazard_detect
    import rv_pipe_pkg::*;
(
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        id_valid,
    input  logic [31:0] id_ins,
    output logic        hazard
);

    logic [1:0] src_used;
    logic [4:0] src_idx [2];
    logic [1:0] src_match;

    assign src_idx[0]  = id_ins[19:15];
    assign src_idx[1]  = id_ins[24:20];
    assign src_used[0] = opcode_legal(id_ins[6:0]);
    assign src_used[1] = opcode_uses_rs2(id_ins[6:0]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_idx[gi] == ex_rd);
        end
    endgenerate

    // A load writing x0 never creates a dependency.
    always_comb begin
        hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                 id_valid && opcode_legal(id_ins[6:0]) && (|src_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion,
// sticky illegal-opcode flag and a saturating bubble counter.
module id_ex_stage
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_ins,
    input  logic [7:0]       id_ctrl,
    input  logic [31:0]      id_rs1_data,
    input  logic [31:0]      id_rs2_data,
    input  logic [31:0]      id_imm,
    input  logic             flush,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [7:0]       ex_ctrl,
    output logic [31:0]      ex_rs1_data,
    output logic [31:0]      ex_rs2_data,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [3:0]       ex_funct,
    output logic             illegal_o,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             hazard;
    logic             id_legal;
    logic             load_bubble;

    logic             ex_valid_reg, ex_valid_next;
    ctrl_t            ex_ctrl_reg, ex_ctrl_next;
    logic [31:0]      opnd_in [3];
    logic [31:0]      opnd_reg [3];
    logic [31:0]      opnd_next [3];
    logic [4:0]       ex_rd_reg, ex_rd_next;
    logic [4:0]       ex_rs1_reg, ex_rs1_next;
    logic [4:0]       ex_rs2_reg, ex_rs2_next;
    logic [3:0]       ex_funct_reg, ex_funct_next;
    logic             illegal_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;

    hazard_detect u_hazard (
        .ex_valid    (ex_valid_reg),
        .ex_mem_read (ex_ctrl_reg[CTRL_MEM_READ]),
        .ex_rd       (ex_rd_reg),
        .id_valid    (id_valid),
        .id_ins      (id_ins),
        .hazard      (hazard)
    );

    // Flush wins over a stall: the squashed instruction needs no holding.
    assign stall_o     = hazard & ~flush;
    assign id_legal    = opcode_legal(id_ins[6:0]);
    assign load_bubble = flush | stall_o | ~id_valid | ~id_legal;

    assign opnd_in[0] = id_rs1_data;
    assign opnd_in[1] = id_rs2_data;
    assign opnd_in[2] = id_imm;

    // Operands clear to zero on a bubble so execute never sees stale data.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_opnd
            assign opnd_next[gi] = load_bubble ? 32'd0 : opnd_in[gi];
        end
    endgenerate

    // Select bubble or decoded instruction for the execute register.
    always_comb begin
        ex_valid_next = 1'b0;
        ex_ctrl_next  = CTRL_BUBBLE;
        ex_rd_next    = 5'd0;
        ex_rs1_next   = 5'd0;
        ex_rs2_next   = 5'd0;
        ex_funct_next = 4'd0;
        if (!load_bubble) begin
            ex_valid_next = 1'b1;
            ex_ctrl_next  = ctrl_t'(id_ctrl);
            ex_rd_next    = id_ins[11:7];
            ex_rs1_next   = id_ins[19:15];
            ex_rs2_next   = id_ins[24:20];
            ex_funct_next = {id_ins[30], id_ins[14:12]};
        end
    end

    // Execute-stage pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= CTRL_BUBBLE;
            opnd_reg[0]  <= 32'd0;
            opnd_reg[1]  <= 32'd0;
            opnd_reg[2]  <= 32'd0;
            ex_rd_reg    <= 5'd0;
            ex_rs1_reg   <= 5'd0;
            ex_rs2_reg   <= 5'd0;
            ex_funct_reg <= 4'd0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            ex_ctrl_reg  <= ex_ctrl_next;
            opnd_reg[0]  <= opnd_next[0];
            opnd_reg[1]  <= opnd_next[1];
            opnd_reg[2]  <= opnd_next[2];
            ex_rd_reg    <= ex_rd_next;
            ex_rs1_reg   <= ex_rs1_next;
            ex_rs2_reg   <= ex_rs2_next;
            ex_funct_reg <= ex_funct_next;
        end
    end

    // Sticky flag: set by any unflushed valid instruction with a bad opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (id_valid && !flush && !id_legal) begin
            illegal_reg <= 1'b1;
        end
    end

    // Count stall bubbles, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_reg <= '0;
        end else if (stall_o && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign ex_ctrl     = ex_ctrl_reg;
    assign ex_rs1_data = opnd_reg[0];
    assign ex_rs2_data = opnd_reg[1];
    assign ex_imm      = opnd_reg[2];
    assign ex_rd       = ex_rd_reg;
    assign ex_rs1      = ex_rs1_reg;
    assign ex_rs2      = ex_rs2_reg;
    assign ex_funct    = ex_funct_reg;
    assign illegal_o   = illegal_reg;
    assign bubble_cnt  = bubble_cnt_reg;

endmodule
